// File: rtl/dvar_mem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter.
//   arb_state_e : arbiter FSM state (IDLE / CLEAR)
//   DVAR_*      : default geometry, clear word and IO starvation limit
//   STAT_W      : width of the optional grant statistics counters
//   sat_inc()   : saturating increment for the statistics counters
package dvar_mem_arbiter_pkg;

  localparam int unsigned DVAR_ADDR_W      = 7;
  localparam int unsigned DVAR_DATA_W      = 32;
  localparam logic [31:0] DVAR_CLR_VALUE   = 32'h0;
  localparam int unsigned DVAR_IO_MAX_WAIT = 4;
  localparam int unsigned STAT_W           = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } arb_state_e;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/dvar_arb_prio.sv
// Grant selection between the CPU and the IO reader, including the IO
// starvation counter that lets IO override the default CPU priority.
// Ports:
//   CLK, RESETn        : clock, async active-low reset
//   cpu_req, io_req    : held requests
//   clr_start          : clear start pulse (suppresses grants this cycle)
//   state              : arbiter FSM state (grants only in IDLE)
//   cpu_gnt, io_gnt    : combinational one-hot grants
module dvar_arb_prio
  import dvar_mem_arbiter_pkg::*;
#(
  parameter int unsigned IO_MAX_WAIT = DVAR_IO_MAX_WAIT
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       cpu_req,
  input  logic       io_req,
  input  logic       clr_start,
  input  arb_state_e state,
  output logic       cpu_gnt,
  output logic       io_gnt
);

  localparam int unsigned WAIT_W = $clog2(IO_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(IO_MAX_WAIT);

  logic [WAIT_W-1:0] io_wait;
  logic [WAIT_W-1:0] io_wait_nxt;
  logic              arb_en;
  logic              io_prio;

  // Grants are gated by reset so they read 0 while RESETn is low.
  always_comb begin
    arb_en      = RESETn && (state == ST_IDLE) && !clr_start;
    io_prio     = io_req && (io_wait == WAIT_MAX);
    io_gnt      = arb_en && io_req && (!cpu_req || io_prio);
    cpu_gnt     = arb_en && cpu_req && !io_prio;
    io_wait_nxt = io_wait;
    if (state == ST_IDLE) begin
      if (io_req && !io_gnt) begin
        io_wait_nxt = (io_wait == WAIT_MAX) ? io_wait : io_wait + WAIT_W'(1);
      end else begin
        io_wait_nxt = '0;
      end
    end
  end

  // Starvation counter; frozen while the clear sweep owns the memory.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      io_wait <= '0;
    end else begin
      io_wait <= io_wait_nxt;
    end
  end

endmodule

// File: rtl/dvar_mem_arbiter.sv
// Arbiter and clear sequencer for the single-port data (variable) memory.
// Shares a 1-cycle-latency synchronous-read memory between the CPU
// (read/write) and the IO/display reader (read-only), and provides a
// hardware sweep that writes CLR_VALUE to every location.
// Optional feature: define DVAR_ARB_STATS_EN to enable 16-bit saturating
// grant counters on stat_cpu_cnt / stat_io_cnt (tied to 0 otherwise).
// Ports:
//   CLK, RESETn                         : clock, async active-low reset
//   cpu_req/we/addr/wdata, cpu_gnt      : CPU request and combinational grant
//   cpu_rvalid, cpu_rdata               : CPU read return (1 cycle after grant)
//   io_req/addr, io_gnt                 : IO read request and grant
//   io_rvalid, io_rdata                 : IO read return
//   clr_start, clr_busy, clr_done       : clear sweep control/status
//   mem_en/we/addr/wdata, mem_rdata     : memory port
//   stat_cpu_cnt, stat_io_cnt           : grant statistics
module dvar_mem_arbiter
  import dvar_mem_arbiter_pkg::*;
#(
  parameter int unsigned       ADDR_W      = DVAR_ADDR_W,
  parameter int unsigned       DATA_W      = DVAR_DATA_W,
  parameter logic [DATA_W-1:0] CLR_VALUE   = DATA_W'(DVAR_CLR_VALUE),
  parameter int unsigned       IO_MAX_WAIT = DVAR_IO_MAX_WAIT
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              io_req,
  input  logic [ADDR_W-1:0] io_addr,
  output logic              io_gnt,
  output logic              io_rvalid,
  output logic [DATA_W-1:0] io_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [STAT_W-1:0] stat_cpu_cnt,
  output logic [STAT_W-1:0] stat_io_cnt
);

  // One extra counter bit so the end of the sweep is seen as DEPTH, not a wrap to 0.
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  arb_state_e        state;
  arb_state_e        state_nxt;
  logic [CNT_W-1:0]  clr_cnt;
  logic [CNT_W-1:0]  clr_cnt_nxt;
  logic              clr_done_nxt;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] io_rdata_q;

  dvar_arb_prio #(
    .IO_MAX_WAIT (IO_MAX_WAIT)
  ) u_prio (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .cpu_req   (cpu_req),
    .io_req    (io_req),
    .clr_start (clr_start),
    .state     (state),
    .cpu_gnt   (cpu_gnt),
    .io_gnt    (io_gnt)
  );

  // Next-state logic for the clear sequencer.
  always_comb begin
    state_nxt    = state;
    clr_cnt_nxt  = clr_cnt;
    clr_done_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clr_start) begin
          state_nxt   = ST_CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      ST_CLEAR: begin
        clr_cnt_nxt = clr_cnt + CNT_W'(1);
        if (clr_cnt_nxt == DEPTH) begin
          state_nxt    = ST_IDLE;
          clr_cnt_nxt  = '0;
          clr_done_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Memory port mux: sweep first, then whichever requester won the grant.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == ST_CLEAR) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = clr_cnt[ADDR_W-1:0];
      mem_wdata = CLR_VALUE;
    end else if (cpu_gnt) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (io_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = io_addr;
    end
  end

  // State, sweep counter and read-return owner tracking.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state       <= ST_IDLE;
      clr_cnt     <= '0;
      clr_done    <= 1'b0;
      cpu_rvalid  <= 1'b0;
      io_rvalid   <= 1'b0;
      cpu_rdata_q <= '0;
      io_rdata_q  <= '0;
    end else begin
      state      <= state_nxt;
      clr_cnt    <= clr_cnt_nxt;
      clr_done   <= clr_done_nxt;
      cpu_rvalid <= cpu_gnt && !cpu_we;
      io_rvalid  <= io_gnt;
      if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
      if (io_rvalid)  io_rdata_q  <= mem_rdata;
    end
  end

  // Read data follows the memory in the rvalid cycle, then holds the captured word.
  assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign io_rdata  = io_rvalid  ? mem_rdata : io_rdata_q;
  assign clr_busy  = (state == ST_CLEAR);

`ifdef DVAR_ARB_STATS_EN
  // Saturating grant counters, cleared only by reset.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      stat_cpu_cnt <= '0;
      stat_io_cnt  <= '0;
    end else begin
      if (cpu_gnt) stat_cpu_cnt <= sat_inc(stat_cpu_cnt);
      if (io_gnt)  stat_io_cnt  <= sat_inc(stat_io_cnt);
    end
  end
`else
  assign stat_cpu_cnt = '0;
  assign stat_io_cnt  = '0;
`endif

endmodule

// File: doc/dvar_mem_arbiter.md
Name: dvar_mem_arbiter

Overview:
Arbitration and sequencing controller for the single-port data (variable) memory, 128 x 32 by default.
- Shares the memory between two requesters: the ARM core (read/write) and the IO/display reader (read-only, DIP-addressed).
- Adds a hardware clear sequencer that sweeps the whole memory.
- Sits between the processor/IO logic and a synchronous-read memory with 1-cycle read latency.

Parameters:
ADDR_W, 7, word address width; memory depth = 2^ADDR_W
DATA_W, 32, data word width
CLR_VALUE, 32'h0, word written to every location by the clear sweep
IO_MAX_WAIT, 4, consecutive denied IO-request cycles after which IO overrides CPU priority (>=1)

Ports:
CLK  in  1  clock, rising edge
RESETn  in  1  asynchronous, active-low reset
cpu_req  in  1  CPU access request; held with addr/we/wdata until cpu_gnt
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_gnt  out  1  combinational grant, same cycle as access issue
cpu_rvalid  out  1  read data valid, one cycle after a granted read
cpu_rdata  out  DATA_W  read data, qualified by cpu_rvalid
io_req  in  1  IO read request; held with io_addr until io_gnt
io_addr  in  ADDR_W  IO word address
io_gnt  out  1  combinational grant
io_rvalid  out  1  read data valid, one cycle after grant
io_rdata  out  DATA_W  read data, qualified by io_rvalid
clr_start  in  1  single-cycle pulse: begin clear sweep
clr_busy  out  1  high while the sweep runs
clr_done  out  1  single-cycle pulse after the last location is written
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en with mem_we = 0
stat_cpu_cnt  out  16  CPU grant count (optional feature)
stat_io_cnt  out  16  IO grant count (optional feature)

Behaviour:
- Reset (RESETn low, asynchronous): the following are all 0:
  - FSM state IDLE; clear address counter; io_wait; rvalid owner flags
  - outputs cpu_gnt, io_gnt, cpu_rvalid, io_rvalid, clr_busy, clr_done, mem_en, mem_we
  - data outputs cpu_rdata, io_rdata
  - stat counters
- FSM has two states: IDLE and CLEAR.
- IDLE, grants:
  - At most one grant per cycle.
  - CPU wins by default.
  - IO wins if io_req and io_wait == IO_MAX_WAIT.
  - A lone requester is always granted.
- IDLE, memory drive:
  - Granted access drives mem_en = 1, mem_addr, and mem_we/mem_wdata in the same cycle.
  - IO grants always have mem_we = 0.
- io_wait (saturating at IO_MAX_WAIT):
  - increments on each cycle with io_req high and io_gnt low;
  - clears on io_gnt or io_req low;
  - holds during CLEAR.
- Read return:
  - A granted read sets the owner's rvalid in the next cycle.
  - The owner's rdata equals mem_rdata in that cycle and holds until the next rvalid.
  - Writes produce no rvalid.
  - Back-to-back grants give one access per cycle at full throughput.
- IDLE -> CLEAR on clr_start. A request arriving in the same cycle is not granted; clear takes precedence.
- CLEAR:
  - Each cycle drives mem_en = 1, mem_we = 1, mem_addr = counter, mem_wdata = CLR_VALUE, then increments the counter.
  - No grants; clr_busy = 1; clr_start is ignored.
  - After address 2^ADDR_W-1 is written, the next cycle is IDLE with clr_done = 1 for one cycle and the counter = 0.
  - The sweep takes exactly 2^ADDR_W cycles.
- A read issued in the cycle before CLEAR entry still returns rvalid in the first CLEAR cycle.
- Reset mid-sweep aborts to IDLE. Memory contents are then partially cleared and are not specified.
- Address counter width is ADDR_W+1 so the terminal condition is detected without wrap aliasing.

Optional Feature:
DVAR_ARB_STATS_EN
- Defined: stat_cpu_cnt and stat_io_cnt increment on each respective grant, saturate at 16'hFFFF, and reset only on RESETn.
- Undefined: both outputs are tied to 0 and no counter flops are synthesized.

Decomposition:
- Shared package holds:
  - state typedef (IDLE, CLEAR)
  - ADDR_W/DATA_W defaults
  - CLR_VALUE default
  - stat counter width constant (16)
- One sub-module: dvar_arb_prio. Combinational plus the io_wait register; produces cpu_gnt/io_gnt from requests, io_wait, and state.
- Clear sequencer and read-return tracking stay in the top module.

Test Plan:
- CPU write addr 5 data 32'hDEADBEEF, then CPU read addr 5 -> cpu_gnt both cycles; mem_we 1 then 0; cpu_rvalid the cycle after the read grant with cpu_rdata 32'hDEADBEEF.
- cpu_req held high continuously plus io_req addr 3 -> IO denied 4 cycles, io_gnt in the 5th cycle, io_rvalid the next cycle; CPU resumes the following cycle.
- clr_start after writing 32'h1234 to addr 127 -> clr_busy 128 cycles, clr_done pulse once, requests ignored meanwhile; subsequent read of addr 127 returns 32'h0.
- clr_start and cpu_req in the same cycle -> no cpu_gnt; CLEAR entered; cpu_gnt the first IDLE cycle after clr_done.
- RESETn low at sweep address 40 -> all outputs 0 asynchronously; after release, IDLE, grants resume, clr_busy 0, no clr_done.
- With DVAR_ARB_STATS_EN, 10 CPU + 3 IO grants -> stat_cpu_cnt 10, stat_io_cnt 3. Without the macro -> both 0.
